// File: rtl/temp_bcd_display.sv
// Converts a binary temperature to three BCD digits with a sequential
// double-dabble, then scans them plus a C/F letter onto a 4-digit display.
module temp_bcd_display #(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  input  logic              unit,
  output logic              busy,
  output logic              bcd_valid,
  output logic [11:0]       bcd,
  output logic [3:0]        an,
  output logic [6:0]        seg
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);
  localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [11:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_unit_q, pend_unit_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              unit_q, unit_d;
  logic              bcd_valid_q, bcd_valid_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [11:0]       adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    pend_unit_d = pend_unit_q;
    bcd_d       = bcd_q;
    unit_d      = unit_q;
    bcd_valid_d = 1'b0;

    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (temp_valid) begin
          shift_d     = temp_data;
          pend_unit_d = unit;
          scratch_d   = '0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // Carries out of the hundreds nibble are dropped, keeping the low 3 digits.
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) state_d = DONE;
      end
      DONE: begin
        bcd_d       = scratch_q;
        unit_d      = pend_unit_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d = (ref_q == REF_LAST) ? '0 : ref_q + REF_W'(1);
    idx_d = (ref_q == REF_LAST) ? idx_q + 2'd1 : idx_q;
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    // Display reads only the latched result, never the in-flight scratch.
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg7(bcd_q[3:0]);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = unit_q ? SEG_F : SEG_C;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      pend_unit_q <= 1'b0;
      bcd_q       <= '0;
      unit_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      ref_q       <= '0;
      idx_q       <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      pend_unit_q <= pend_unit_d;
      bcd_q       <= bcd_d;
      unit_q      <= unit_d;
      bcd_valid_q <= bcd_valid_d;
      ref_q       <= ref_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign bcd_valid = bcd_valid_q;
  assign bcd       = bcd_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_temp_bcd_display.sv
// Scoreboarded bench for temp_bcd_display: stimulus pushes expected BCD words,
// a negedge monitor pops them on every bcd_valid pulse.
module tb_temp_bcd_display;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_C     = 7'b1000110;
  localparam logic [6:0] S_F     = 7'b0001110;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        temp_valid = 1'b0;
  logic [7:0]  temp_data = '0;
  logic        unit = 1'b0;
  logic        busy, bcd_valid;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [11:0] sb[$];
  int vcyc[$];
  logic [11:0] exp_word;

  temp_bcd_display #(.DATA_W(8), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temp_data(temp_data),
    .unit(unit), .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: every bcd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bcd_valid) begin
      vcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_bcd_valid", 1, 0);
      end else begin
        exp_word = sb.pop_front();
        chk("sb_bcd", int'(bcd), int'(exp_word));
      end
    end
  end

  task automatic conv(input logic [7:0] d, input logic u, input logic [11:0] exp_bcd);
    int n;
    @(negedge clk);
    temp_valid = 1'b1; temp_data = d; unit = u;
    sb.push_back(exp_bcd);
    @(negedge clk);
    temp_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 9);
    chk("bcd_after_conv", int'(bcd), int'(exp_bcd));
  endtask

  task automatic chk_disp(input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    int n;
    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    seg_exp[0] = s0; seg_exp[1] = s1; seg_exp[2] = s2; seg_exp[3] = s3;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (an !== an_exp[k] && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("an_digit%0d", k), int'(an), int'(an_exp[k]));
      chk($sformatf("seg_digit%0d", k), int'(seg), int'(seg_exp[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    repeat (3) @(negedge clk);
    chk("rst_an", int'(an), 4'hF);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bcd_valid", int'(bcd_valid), 0);

    rst_n = 1'b1;
    @(negedge clk);
    n = 0;
    while (an == 4'b1110 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("scan_hold_cycles", n, 4);
    chk_disp(S0, S_BLANK, S_BLANK, S_C);

    conv(8'd212, 1'b1, 12'h212);
    chk_disp(S2, S1, S2, S_F);

    conv(8'd7, 1'b0, 12'h007);
    chk_disp(S7, S_BLANK, S_BLANK, S_C);

    conv(8'd255, 1'b0, 12'h255);
    chk_disp(S5, S5, S2, S_C);

    // 100 accepted; 50 pulsed while busy at cycles 3 and 9 must be dropped.
    @(negedge clk);
    temp_valid = 1'b1; temp_data = 8'd100; unit = 1'b0;
    sb.push_back(12'h100);
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_at_cycle3", int'(busy), 1);
    temp_valid = 1'b1; temp_data = 8'd50;
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_at_cycle9", int'(busy), 1);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("bcd_after_ignored", int'(bcd), 12'h100);
    chk("busy_after_ignored", int'(busy), 0);

    // Back-to-back with temp_valid held high.
    base = vcyc.size();
    @(negedge clk);
    temp_valid = 1'b1; temp_data = 8'd32; unit = 1'b0;
    sb.push_back(12'h032);
    sb.push_back(12'h098);
    @(negedge clk);
    temp_data = 8'd98;
    repeat (10) @(negedge clk);
    temp_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_pulses", vcyc.size() - base, 2);
    if (vcyc.size() >= base + 2) chk("b2b_gap", vcyc[base+1] - vcyc[base], 10);
    chk("b2b_last_bcd", int'(bcd), 12'h098);

    conv(8'd32, 1'b0, 12'h032);
    chk_disp(S2, S3, S_BLANK, S_C);

    // Reset during SHIFT aborts the conversion.
    conv(8'd212, 1'b1, 12'h212);
    @(negedge clk);
    temp_valid = 1'b1; temp_data = 8'd150; unit = 1'b0;
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_bcd", int'(bcd), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_an", int'(an), 4'hF);
    chk("abort_bcd_valid", int'(bcd_valid), 0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_bcd_later", int'(bcd), 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_bcd_display.md
Name: temp_bcd_display

Overview:
- Downstream consumer of the temperature-conversion ROM. Accepts one converted binary temperature plus its unit flag, converts it to 3 BCD digits with a sequential double-dabble, and drives a multiplexed 4-digit active-low seven-segment display.
- Digit layout is hundreds, tens, ones, then a unit letter.
- The displayed value holds until the next conversion completes.

Parameters:
- DATA_W, 8: width of the binary temperature input; values 0..255 are displayed.
- REFRESH_DIV, 100000: clk cycles each digit is lit before the scan advances; minimum value is 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- temp_valid  input  1  temp_data/unit valid this cycle
- temp_data  input  DATA_W  converted temperature from the ROM stage
- unit  input  1  1 = value is Fahrenheit, 0 = value is Celsius
- busy  output  1  conversion in progress; temp_valid is ignored while high
- bcd_valid  output  1  one-cycle pulse when new digits are latched
- bcd  output  12  {hundreds, tens, ones} of the last completed conversion
- an  output  4  digit enables, active-low; an[0] = ones … an[3] = unit letter
- seg  output  7  segments, active-low, seg[6:0] = g..a

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at an edge):
  - FSM state = IDLE; busy = 0; bcd_valid = 0; bcd = 0.
  - Latched unit = 0 (C).
  - Scan index = 0; refresh counter = 0.
  - an = 4'b1111; seg = 7'b1111111.
- Reset mid-conversion aborts the conversion. bcd is not updated, and no bcd_valid pulse is produced.
- FSM states: IDLE, SHIFT, DONE. busy = (state != IDLE).
- IDLE:
  - If temp_valid = 1 at edge E0, capture temp_data into the shift register and unit into the pending unit.
  - Clear the BCD scratch register and shift counter, then go to SHIFT.
  - temp_valid while SHIFT or DONE is dropped, with no queueing.
- SHIFT:
  - At each edge, add 3 to each scratch BCD nibble that is >= 5.
  - Then shift {scratch, shift register} left by 1.
  - After exactly DATA_W such edges (E1..E_DATA_W), go to DONE.
- DONE:
  - At edge E_DATA_W+1, load bcd from scratch and the latched unit from the pending unit.
  - Assert bcd_valid for exactly this one cycle, and go to IDLE.
- Latency: for DATA_W = 8, bcd is updated 9 edges after the capture edge.
  - busy is high for 9 cycles.
  - A new temp_valid is accepted in the first cycle busy is low.
- Back-to-back: a temp_valid held high continuously gives one conversion every DATA_W+2 cycles.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the scan index advances 0→1→2→3→0.
  - The counter runs independently of the FSM.
- Outputs are registered from the scan index and display state: an and seg change 1 edge after the index changes.
  - The first edge after reset release loads an = 1110 and seg = pattern of ones digit.
- Digit selection (an, seg):
  - index 0: an = 1110, seg = ones.
  - index 1: an = 1101, seg = tens, blank if hundreds = 0 and tens = 0.
  - index 2: an = 1011, seg = hundreds, blank if hundreds = 0.
  - index 3: an = 0111, seg = C (1000110) if latched unit = 0, else F (0001110).
  - Ones is never blanked.
- Segment patterns (g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- The display shows the previous bcd and unit throughout a conversion; it never shows partial scratch values.
- DATA_W > 8: bcd shows only the low 3 decimal digits. Values >= 1000 are out of scope for verification.

Test Plan:
- Reset then idle, REFRESH_DIV = 4 → bcd = 0, busy = 0; scan cycles an 1110/1101/1011/0111, each held 4 cycles; seg = 1000000, blank, blank, 1000110.
- temp_valid for 1 cycle, temp_data = 212, unit = 1 → busy high 9 cycles; bcd_valid pulses once; bcd = 12'h212; digits show 0100100, 1111001, 0100100, 0001110.
- temp_data = 7, unit = 0 → bcd = 12'h007; hundreds and tens blank, ones = 1111000, letter = 1000110. Then temp_data = 255 → bcd = 12'h255.
- temp_data = 100 accepted, then temp_data = 50 pulsed at cycles 3 and 9 after capture (busy high) → ignored; bcd = 12'h100, single bcd_valid.
- temp_valid held high with 32 then 98 → two conversions 10 cycles apart; bcd = 12'h032 then 12'h098; tens not blanked for 32 (hundreds blank).
- rst_n low during cycle 4 of SHIFT (prior bcd = 12'h212) → bcd = 0, busy = 0, no bcd_valid pulse, an = 1111 at that edge.
